fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 38 +++
 rtl/fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
// Instruction-memory request/response bus between the fetch sequencer and
// the instruction memory. At most one request is outstanding at a time.
//
//   imem_req_o     request valid (sequencer -> memory)
//   imem_addr_o    request address (sequencer -> memory)
//   imem_gnt_i     request accepted this cycle (memory -> sequencer)
//   imem_rvalid_i  read data valid, one per grant (memory -> sequencer)
//   imem_rdata_i   fetched instruction (memory -> sequencer)
//
// Modports: master = sequencer side, slave = memory side.
// ----------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch sequencer: issues one instruction-memory request at a
// time from the PC register, places each returned instruction in a one-entry
// output register for decode, and handles decode stalls and redirects
// (branches/jumps), discarding responses that belong to an abandoned path.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rstn           synchronous active-low reset
//   Pc_rstn        synchronous active-low PC restart (same effect as rstn)
//   stall_i        decode not accepting; output register is held
//   redirect_i     restart fetch at redirect_pc_i
//   redirect_pc_i  redirect target
//   imem           instruction memory bus (fetch_sequencer_if.master)
//   if_valid_o     output register holds an instruction for decode
//   if_instr_o     instruction
//   if_pc_o        address of that instruction
//   misalign_o     misaligned redirect trap (only with the macro below)
//
// Configuration macro: FETCH_SEQ_MISALIGN_TRAP_EN
//   defined   : a redirect to a non word-aligned target raises misalign_o
//               and parks fetch until an aligned redirect or a reset.
//   undefined : the low two target bits are ignored and fetch proceeds.
// ----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                Pc_rstn,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  fetch_sequencer_if.master   imem,
  output logic                if_valid_o,
  output logic [XLEN-1:0]     if_instr_o,
  output logic [XLEN-1:0]     if_pc_o
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  ,
  output logic                misalign_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] issued_q, issued_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic            misal_q, misal_d;

  logic [XLEN-1:0] target;
  logic            target_bad;
  logic            req;
  logic            grant;
  logic            rvalid;

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  assign target     = redirect_pc_i;
  assign target_bad = |redirect_pc_i[1:0];
`else
  // Low two bits are forced to zero; no trap exists in this build.
  assign target     = redirect_pc_i & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign target_bad = 1'b0;
`endif

  // A request is withheld while decode is stalled on a full output register,
  // so a granted response always has a free slot to land in.
  assign req    = (state_q == S_REQ) && !(valid_q && stall_i);
  assign grant  = req && imem.imem_gnt_i;
  assign rvalid = imem.imem_rvalid_i;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_q;

  assign if_valid_o = valid_q;
  assign if_instr_o = instr_q;
  assign if_pc_o    = opc_q;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  assign misalign_o = misal_q;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    issued_d = issued_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    misal_d  = misal_q;

    // Decode consumes the output register; a reload below overrides this.
    if (valid_q && !stall_i) valid_d = 1'b0;

    if (redirect_i) begin
      valid_d = 1'b0;
      pc_d    = target;
      misal_d = target_bad;
      if (state_q == S_DRAIN) begin
        // Still owed one response: keep draining unless it arrives now.
        if (rvalid) state_d = target_bad ? S_HOLD : S_REQ;
        else        state_d = S_DRAIN;
      end else if ((state_q == S_REQ && grant) || (state_q == S_WAIT && !rvalid)) begin
        // A response for the old path is in flight and must be swallowed.
        state_d = S_DRAIN;
      end else begin
        // Nothing outstanding (a same-cycle rvalid is simply dropped).
        state_d = target_bad ? S_HOLD : S_REQ;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (grant) begin
            issued_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (rvalid) begin
            valid_d = 1'b1;
            instr_d = imem.imem_rdata_i;
            opc_d   = issued_q;
            state_d = stall_i ? S_HOLD : S_REQ;
          end
        end
        S_HOLD: begin
          // A misaligned trap parks here until an aligned redirect.
          if (!stall_i && !misal_q) state_d = S_REQ;
        end
        S_DRAIN: begin
          if (rvalid) state_d = misal_q ? S_HOLD : S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || !Pc_rstn) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      issued_q <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opc_q    <= '0;
      misal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      issued_q <= issued_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      misal_q  <= misal_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rstn;
  logic        Pc_rstn;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  fetch_sequencer_if #(.XLEN(32)) mif ();

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .Pc_rstn       (Pc_rstn),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (mif),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o)
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  int pass_cnt = 0;
  int total    = 0;

  // Memory responder state
  int          lat   = 1;
  logic        pend  = 1'b0;
  int          pcnt  = 0;
  logic [31:0] paddr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // One clock: sample the bus at the negedge, advance, then update the
  // memory model (rvalid is asserted lat edges after the grant edge).
  task automatic cyc();
    logic        g;
    logic        r;
    logic [31:0] a;
    @(negedge clk);
    g = mif.imem_req_o && mif.imem_gnt_i;
    a = mif.imem_addr_o;
    r = !rstn || !Pc_rstn;
    @(posedge clk);
    #1;
    mif.imem_rvalid_i = 1'b0;
    if (r) begin
      pend = 1'b0;
    end else begin
      if (g === 1'b1) begin
        pend  = 1'b1;
        pcnt  = lat;
        paddr = a;
      end
      if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          mif.imem_rvalid_i = 1'b1;
          mif.imem_rdata_i  = instr_of(paddr);
          pend = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    rstn = 1'b1;
    #1;
    total++; if (if_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid_o); else pass_cnt++;
    total++; if (if_instr_o !== 32'h0) $display("FAIL reset_instr: got %h want 0", if_instr_o); else pass_cnt++;
    total++; if (if_pc_o !== 32'h0) $display("FAIL reset_pc: got %h want 0", if_pc_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", mif.imem_req_o); else pass_cnt++;
    total++; if (mif.imem_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", mif.imem_addr_o); else pass_cnt++;
  endtask

  task automatic test_sequential();
    logic [31:0] ep;
    cyc();
    total++; if (mif.imem_req_o !== 1'b1) $display("FAIL seq_first_req: got %b want 1", mif.imem_req_o); else pass_cnt++;
    total++; if (mif.imem_addr_o !== 32'h0) $display("FAIL seq_first_addr: got %h want 0", mif.imem_addr_o); else pass_cnt++;
    cyc();
    total++; if (mif.imem_req_o !== 1'b0) $display("FAIL seq_wait_req: got %b want 0", mif.imem_req_o); else pass_cnt++;
    cyc();
    total++; if (if_valid_o !== 1'b1) $display("FAIL seq_valid0: got %b want 1", if_valid_o); else pass_cnt++;
    total++; if (if_pc_o !== 32'h0) $display("FAIL seq_pc0: got %h want 0", if_pc_o); else pass_cnt++;
    total++; if (if_instr_o !== 32'h5A5A_0000) $display("FAIL seq_instr0: got %h want 5a5a0000", if_instr_o); else pass_cnt++;
    total++; if (mif.imem_addr_o !== 32'h4) $display("FAIL seq_addr1: got %h want 4", mif.imem_addr_o); else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      ep = 32'(4 * k);
      cyc();
      total++; if (if_valid_o !== 1'b0) $display("FAIL seq_gap%0d: got %b want 0", k, if_valid_o); else pass_cnt++;
      cyc();
      total++; if (if_valid_o !== 1'b1) $display("FAIL seq_valid%0d: got %b want 1", k, if_valid_o); else pass_cnt++;
      total++; if (if_pc_o !== ep) $display("FAIL seq_pc%0d: got %h want %h", k, if_pc_o, ep); else pass_cnt++;
      total++; if (if_instr_o !== (ep ^ 32'h5A5A_0000)) $display("FAIL seq_instr%0d: got %h want %h", k, if_instr_o, ep ^ 32'h5A5A_0000); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    #1;
    total++; if (mif.imem_req_o !== 1'b0) $display("FAIL stall_req_now: got %b want 0", mif.imem_req_o); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++; if (if_valid_o !== 1'b1) $display("FAIL stall_valid%0d: got %b want 1", i, if_valid_o); else pass_cnt++;
      total++; if (if_pc_o !== 32'hC) $display("FAIL stall_pc%0d: got %h want c", i, if_pc_o); else pass_cnt++;
      total++; if (if_instr_o !== 32'h5A5A_000C) $display("FAIL stall_instr%0d: got %h want 5a5a000c", i, if_instr_o); else pass_cnt++;
      total++; if (mif.imem_req_o !== 1'b0) $display("FAIL stall_req%0d: got %b want 0", i, mif.imem_req_o); else pass_cnt++;
    end
    stall_i = 1'b0;
    #1;
    total++; if (mif.imem_addr_o !== 32'h10) $display("FAIL stall_resume_addr: got %h want 10", mif.imem_addr_o); else pass_cnt++;
    cyc();
    total++; if (if_valid_o !== 1'b0) $display("FAIL stall_consumed: got %b want 0", if_valid_o); else pass_cnt++;
    cyc();
    total++; if (if_pc_o !== 32'h10 || if_valid_o !== 1'b1) $display("FAIL stall_next_pc: got %h/%b want 10/1", if_pc_o, if_valid_o); else pass_cnt++;
  endtask

  task automatic test_redirect_wait();
    lat = 3;
    cyc();  // grant at 0x14
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cyc();
    redirect_i = 1'b0;
    total++; if (if_valid_o !== 1'b0) $display("FAIL rdw_valid: got %b want 0", if_valid_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b0) $display("FAIL rdw_drain_req: got %b want 0", mif.imem_req_o); else pass_cnt++;
    cyc();
    total++; if (mif.imem_req_o !== 1'b0) $display("FAIL rdw_drain_req2: got %b want 0", mif.imem_req_o); else pass_cnt++;
    cyc();  // stale response arrives here
    total++; if (if_valid_o !== 1'b0) $display("FAIL rdw_stale_valid: got %b want 0", if_valid_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h100) $display("FAIL rdw_new_req: got %b/%h want 1/100", mif.imem_req_o, mif.imem_addr_o); else pass_cnt++;
    lat = 1;
    cyc();
    cyc();
    total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100) $display("FAIL rdw_fetch: got %b/%h want 1/100", if_valid_o, if_pc_o); else pass_cnt++;
    total++; if (if_instr_o !== 32'h5A5A_0100) $display("FAIL rdw_instr: got %h want 5a5a0100", if_instr_o); else pass_cnt++;
  endtask

  task automatic test_redirect_rvalid();
    cyc();  // grant at 0x104, rvalid due next edge
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    cyc();
    redirect_i = 1'b0;
    total++; if (if_valid_o !== 1'b0) $display("FAIL rdr_valid: got %b want 0", if_valid_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h200) $display("FAIL rdr_req: got %b/%h want 1/200", mif.imem_req_o, mif.imem_addr_o); else pass_cnt++;
    cyc();  // grant at 0x200
    redirect_i = 1'b1; redirect_pc_i = 32'h200; stall_i = 1'b1;
    cyc();
    redirect_i = 1'b0;
    total++; if (if_valid_o !== 1'b0) $display("FAIL rdr_stall_valid: got %b want 0", if_valid_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h200) $display("FAIL rdr_stall_req: got %b/%h want 1/200", mif.imem_req_o, mif.imem_addr_o); else pass_cnt++;
    stall_i = 1'b0;
    cyc();
    cyc();
    total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h200) $display("FAIL rdr_fetch: got %b/%h want 1/200", if_valid_o, if_pc_o); else pass_cnt++;
  endtask

  task automatic test_hold();
    cyc();  // grant at 0x204
    stall_i = 1'b1;
    cyc();  // response lands while stalled
    total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h204) $display("FAIL hold_load: got %b/%h want 1/204", if_valid_o, if_pc_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b0) $display("FAIL hold_req: got %b want 0", mif.imem_req_o); else pass_cnt++;
    cyc();
    total++; if (if_valid_o !== 1'b1 || mif.imem_req_o !== 1'b0) $display("FAIL hold_keep: got %b/%b want 1/0", if_valid_o, mif.imem_req_o); else pass_cnt++;
    stall_i = 1'b0;
    cyc();
    total++; if (if_valid_o !== 1'b0) $display("FAIL hold_consume: got %b want 0", if_valid_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h208) $display("FAIL hold_resume: got %b/%h want 1/208", mif.imem_req_o, mif.imem_addr_o); else pass_cnt++;
  endtask

  task automatic test_wrap_pcrst();
    mif.imem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cyc();
    redirect_i = 1'b0; mif.imem_gnt_i = 1'b1;
    total++; if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_req: got %b/%h want 1/fffffffc", mif.imem_req_o, mif.imem_addr_o); else pass_cnt++;
    cyc();
    total++; if (mif.imem_addr_o !== 32'h0) $display("FAIL wrap_addr: got %h want 0", mif.imem_addr_o); else pass_cnt++;
    cyc();
    total++; if (if_pc_o !== 32'hFFFF_FFFC || if_valid_o !== 1'b1) $display("FAIL wrap_fetch: got %h/%b want fffffffc/1", if_pc_o, if_valid_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h0) $display("FAIL wrap_next: got %b/%h want 1/0", mif.imem_req_o, mif.imem_addr_o); else pass_cnt++;
    cyc();  // grant at 0 -> WAIT
    Pc_rstn = 1'b0;
    cyc();
    Pc_rstn = 1'b1;
    #1;
    total++; if (if_valid_o !== 1'b0) $display("FAIL pcrst_valid: got %b want 0", if_valid_o); else pass_cnt++;
    total++; if (if_pc_o !== 32'h0 || if_instr_o !== 32'h0) $display("FAIL pcrst_out: got %h/%h want 0/0", if_pc_o, if_instr_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b0 || mif.imem_addr_o !== 32'h0) $display("FAIL pcrst_req: got %b/%h want 0/0", mif.imem_req_o, mif.imem_addr_o); else pass_cnt++;
    cyc();
    total++; if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h0) $display("FAIL pcrst_restart: got %b/%h want 1/0", mif.imem_req_o, mif.imem_addr_o); else pass_cnt++;
    cyc();
    cyc();
    total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0) $display("FAIL pcrst_fetch: got %b/%h want 1/0", if_valid_o, if_pc_o); else pass_cnt++;
  endtask

  task automatic test_misalign();
    mif.imem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    cyc();
    redirect_i = 1'b0;
    total++; if (if_valid_o !== 1'b0) $display("FAIL mis_valid: got %b want 0", if_valid_o); else pass_cnt++;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    total++; if (misalign_o !== 1'b1) $display("FAIL mis_flag: got %b want 1", misalign_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b0) $display("FAIL mis_noreq: got %b want 0", mif.imem_req_o); else pass_cnt++;
    mif.imem_gnt_i = 1'b1;
    cyc();
    cyc();
    total++; if (mif.imem_req_o !== 1'b0 || misalign_o !== 1'b1) $display("FAIL mis_parked: got %b/%b want 0/1", mif.imem_req_o, misalign_o); else pass_cnt++;
    redirect_i = 1'b1; redirect_pc_i = 32'h104;
    cyc();
    redirect_i = 1'b0;
    total++; if (misalign_o !== 1'b0) $display("FAIL mis_clear: got %b want 0", misalign_o); else pass_cnt++;
    total++; if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h104) $display("FAIL mis_req: got %b/%h want 1/104", mif.imem_req_o, mif.imem_addr_o); else pass_cnt++;
    cyc();
    cyc();
    total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h104) $display("FAIL mis_fetch: got %b/%h want 1/104", if_valid_o, if_pc_o); else pass_cnt++;
`else
    total++; if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h100) $display("FAIL mis_forced: got %b/%h want 1/100", mif.imem_req_o, mif.imem_addr_o); else pass_cnt++;
    mif.imem_gnt_i = 1'b1;
    cyc();
    cyc();
    total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100) $display("FAIL mis_fetch: got %b/%h want 1/100", if_valid_o, if_pc_o); else pass_cnt++;
    total++; if (if_instr_o !== 32'h5A5A_0100) $display("FAIL mis_instr: got %h want 5a5a0100", if_instr_o); else pass_cnt++;
`endif
  endtask

  initial begin
    rstn              = 1'b0;
    Pc_rstn           = 1'b1;
    stall_i           = 1'b0;
    redirect_i        = 1'b0;
    redirect_pc_i     = '0;
    mif.imem_gnt_i    = 1'b1;
    mif.imem_rvalid_i = 1'b0;
    mif.imem_rdata_i  = '0;

    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_hold();
    test_wrap_pcrst();
    test_misalign();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
